serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor sequencer. It time-shares a single 1-bit full-adder cell, built from two half-add cells (s = a^b, c = a&b), across WIDTH cycles to produce a WIDTH-bit sum/difference plus carry. It sits between the top-level pin wrapper and the half-add datapath, and owns operand capture, bit sequencing, the carry register and the start/busy/done handshake.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; captured with the operands.
- op_a  input  WIDTH  operand A; captured when start is accepted.
- op_b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- sum  output  WIDTH  result register; holds until the next accepted start.
- cout  output  1  final carry. For sub=1 it is the inverted borrow: 1 means A >= B unsigned.

Behaviour:
- Reset is synchronous and active-high. While rst is high at a clock edge:
  - state goes to IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - bit counter, carry register and shift registers are cleared.
- rst has priority over every other input, including mid-RUN. An aborted operation never produces done.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE when the last bit is processed.
  - DONE -> IDLE unconditionally.
- Start acceptance:
  - In IDLE with start=1 at edge k: latch a_sh=op_a, b_sh = sub ? ~op_b : op_b, carry=sub, cnt=0, clear sum shift register.
  - start in RUN or DONE is ignored; there is no queueing.
  - op_a, op_b and sub changes after acceptance have no effect.
- RUN, one bit per cycle, LSB first:
  - s1,c1 = HA(a_sh[0], b_sh[0]);
  - s,c2 = HA(s1, carry);
  - carry <= c1|c2;
  - a_sh and b_sh shift right;
  - sum_sh shifts right with s inserted at the MSB;
  - cnt increments.
  - When cnt == WIDTH-1 on an edge, the next state is DONE.
- Timing (start high in cycle 0):
  - cycles 1..WIDTH: busy=1, done=0;
  - cycle WIDTH+1: done=1, busy=0, sum and cout valid;
  - cycle WIDTH+2: IDLE, and a new start can be accepted.
  - Start-to-done latency is WIDTH+1 cycles. Maximum throughput is one operation per WIDTH+2 cycles.
- sum and cout registers:
  - updated at the edge entering DONE;
  - held through DONE and IDLE;
  - during RUN they hold the previous result, not partial data.
- Arithmetic is modulo 2^WIDTH. No signed-overflow flag.
- Counter width is clog2(WIDTH). cnt never wraps, because the RUN exit is decoded at WIDTH-1.
- start held high continuously: a new operation is accepted every WIDTH+2 cycles, and done pulses once per operation.
- start and rst high on the same edge: reset wins and start is dropped.

Decomposition:
- Shared package serial_add_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 decodes to IDLE);
  - the constant DEFAULT_WIDTH=8;
  - a clog2 helper function.
- One sub-module, half_add_cell: inputs a, b; outputs s, c; purely combinational. It is instantiated twice for the full-adder slice.
- Control FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan (WIDTH=8):
1. Basic add: start with op_a=8'h35, op_b=8'h4A, sub=0 in cycle 0 -> busy high in cycles 1-8; done=1 only in cycle 9; sum=8'h7F, cout=0.
2. Carry wrap: 8'hFF + 8'h01 -> sum=8'h00, cout=1.
3. Subtract:
   - 8'h10 - 8'h01 -> sum=8'h0F, cout=1.
   - 8'h00 - 8'h01 -> sum=8'hFF, cout=0.
4. Ignored inputs: start 8'h35+8'h4A, then in cycle 3 pulse start with op_a=8'hAA, change op_b and sub -> cycle 9 result still 8'h7F; no second done.
5. Back-to-back: start held high with 8'h01+8'h02 -> done in cycles 9, 19, 29...; sum=8'h03 each time; busy low exactly in the DONE and IDLE cycles.
6. Reset mid-op: start 8'hFF+8'hFF; first run to completion (sum=8'hFE, cout=1); then start again with 8'h35+8'h4A, and assert rst in cycle 4 of RUN -> next cycle busy=0, sum=0, cout=0, state IDLE; no done; a following start with 8'h35+8'h4A yields sum=8'h7F.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // The unused encoding 2'd3 is handled as IDLE by the control FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_add_half_add_cell.sv
// One-bit half adder; two of these form the serial full-adder slice.
module half_add_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: captures operands, walks one bit per cycle
// LSB first through a shared full-adder slice, and publishes sum/cout on done.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             s1, c1, s, c2;

    half_add_cell u_ha0 (.a(a_q[0]), .b(b_q[0]),  .s(s1), .c(c1));
    half_add_cell u_ha1 (.a(s1),     .b(carry_q), .s(s),  .c(c2));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = {s, sh_q[WIDTH-1:1]};
                carry_d = c1 | c2;
                // Exit decoded at WIDTH-1 so the counter never wraps.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = {s, sh_q[WIDTH-1:1]};
                    cout_d  = c1 | c2;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: begin
                // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                if (start) begin
                    state_d = RUN;
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;
    localparam logic [15:0] EXP_BUSY = 16'h01FE;  // busy in cycles 1..8
    localparam logic [15:0] EXP_DONE = 16'h0200;  // done only in cycle 9

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [W-1:0] op_a, op_b, sum;
    logic         busy, done, cout;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic; cout is carry-out or "no borrow".
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        if (s) begin
            r = (ia - ib) & 255;
            return {(ia >= ib), r[W-1:0]};
        end
        r = ia + ib;
        return {(r > 255), r[W-1:0]};
    endfunction

    // Starts an op in the current cycle (cycle 0) and records outputs up to cycle W+2.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [15:0] bmask, output logic [15:0] dmask,
                          output logic [W-1:0] mid, output logic [W-1:0] rsum, output logic rcout);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        bmask = '0; dmask = '0; mid = '0; rsum = '0; rcout = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
            end
            bmask[c] = busy;
            dmask[c] = done;
            if (c == W) mid = sum;
            if (c == W + 1) begin rsum = sum; rcout = cout; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; sub = 1'b1; op_a = 8'hFF; op_b = 8'h01;
        tick(); tick(); tick();
        tests++;
        if ({busy, done, sum, cout} !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        prev_sum = '0; prev_cout = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{8'h35, 8'hFF, 8'h10, 8'h00, 8'h80};
        logic [W-1:0] vb[5] = '{8'h4A, 8'h01, 8'h01, 8'h01, 8'h80};
        logic         vs[5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [W-1:0] ws[5] = '{8'h7F, 8'h00, 8'h0F, 8'hFF, 8'h00};
        logic         wc[5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [15:0]  bm, dm;
        logic [W-1:0] mid, rs;
        logic         rc;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vs[i], bm, dm, mid, rs, rc);
            tests++;
            if (bm !== EXP_BUSY || dm !== EXP_DONE) begin
                fails++;
                $display("FAIL directed%0d timing: busy=%h done=%h, want %h %h", i, bm, dm, EXP_BUSY, EXP_DONE);
            end
            tests++;
            if (mid !== prev_sum) begin
                fails++;
                $display("FAIL directed%0d hold: sum during RUN=%h, want previous %h", i, mid, prev_sum);
            end
            tests++;
            if ({rc, rs} !== {wc[i], ws[i]}) begin
                fails++;
                $display("FAIL directed%0d result: sum=%h cout=%b, want %h %b", i, rs, rc, ws[i], wc[i]);
            end
            prev_sum = ws[i]; prev_cout = wc[i];
        end
    endtask

    task automatic test_random();
        logic [15:0]  bm, dm;
        logic [W-1:0] a, b, mid, rs;
        logic         s, rc;
        logic [W:0]   exp;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom);
            if (i % 6 == 0) b = a;
            exp = model(a, b, s);
            run_op(a, b, s, bm, dm, mid, rs, rc);
            tests++;
            if ({rc, rs} !== exp || bm !== EXP_BUSY || dm !== EXP_DONE || mid !== prev_sum) begin
                fails++;
                $display("FAIL random%0d: %h %s %h -> sum=%h cout=%b busy=%h done=%h mid=%h, want %h %b %h %h %h",
                         i, a, s ? "-" : "+", b, rs, rc, bm, dm, mid, exp[W-1:0], exp[W], EXP_BUSY, EXP_DONE, prev_sum);
            end
            prev_sum = exp[W-1:0]; prev_cout = exp[W];
        end
    endtask

    task automatic test_ignored();
        int ndone = 0;
        int dcyc = -1;
        logic [W-1:0] rs = '0;
        op_a = 8'h35; op_b = 8'h4A; sub = 1'b0; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start = 1'b0;
            if (c == 3) begin start = 1'b1; op_a = 8'hAA; op_b = 8'h13; sub = 1'b1; end
            if (done) begin ndone++; if (dcyc < 0) begin dcyc = c; rs = sum; end end
        end
        tests++;
        if (ndone != 1 || dcyc != 9 || rs !== 8'h7F) begin
            fails++;
            $display("FAIL ignored: dones=%0d first at cycle %0d sum=%h, want 1 at 9 sum=7f", ndone, dcyc, rs);
        end
        prev_sum = 8'h7F; prev_cout = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic edone, ebusy;
        op_a = 8'h01; op_b = 8'h02; sub = 1'b0; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            edone = (c % 10 == 9);
            ebusy = !((c % 10 == 9) || (c % 10 == 0));
            tests++;
            if (done !== edone || busy !== ebusy) begin
                fails++;
                $display("FAIL b2b cycle %0d: busy=%b done=%b, want %b %b", c, busy, done, ebusy, edone);
            end
            if (edone) begin
                tests++;
                if (sum !== 8'h03 || cout !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b sum cycle %0d: sum=%h cout=%b, want 03 0", c, sum, cout);
                end
            end
        end
        start = 1'b0;
        tick(); tick();
        prev_sum = 8'h03; prev_cout = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0]  bm, dm;
        logic [W-1:0] mid, rs;
        logic         rc;
        int           nd = 0;
        run_op(8'hFF, 8'hFF, 1'b0, bm, dm, mid, rs, rc);
        tests++;
        if ({rc, rs} !== {1'b1, 8'hFE}) begin
            fails++;
            $display("FAIL rstmid first: sum=%h cout=%b, want fe 1", rs, rc);
        end
        op_a = 8'h35; op_b = 8'h4A; sub = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, done, sum, cout} !== '0) begin
            fails++;
            $display("FAIL rstmid abort: busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy) nd++;
        end
        tests++;
        if (nd != 0) begin
            fails++;
            $display("FAIL rstmid idle: %0d active cycles after abort, want 0", nd);
        end
        // start coinciding with reset is dropped
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_start: busy=%b after start with reset, want 0", busy);
        end
        prev_sum = '0;
        run_op(8'h35, 8'h4A, 1'b0, bm, dm, mid, rs, rc);
        tests++;
        if ({rc, rs} !== {1'b0, 8'h7F} || dm !== EXP_DONE || mid !== 8'h00) begin
            fails++;
            $display("FAIL rstmid rerun: sum=%h cout=%b done=%h mid=%h, want 7f 0 %h 00", rs, rc, dm, EXP_DONE, mid);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        prev_sum = '0; prev_cout = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
